// File: rtl/cipher_uut_sequencer_if.sv
// Host-side request/result bundle between the autotest controller and the
// cipher UUT sequencer.
//   master : autotest controller (drives the test vector, reads the verdict)
//   slave  : cipher_uut_sequencer
// Signals: start/mode/block/key/expected (request), busy/done/pass/timeout/
// err/latency (status and verdict).
interface cipher_uut_sequencer_if #(
    parameter int unsigned BLOCK_W = 64,
    parameter int unsigned KEY_W   = 80,
    parameter int unsigned CNT_W   = 16
);
    logic               start;
    logic [1:0]         mode;
    logic [BLOCK_W-1:0] block;
    logic [KEY_W-1:0]   key;
    logic [BLOCK_W-1:0] expected;
    logic               busy;
    logic               done;
    logic               pass;
    logic               timeout;
    logic               err;
    logic [CNT_W-1:0]   latency;

    modport master (
        output start, mode, block, key, expected,
        input  busy, done, pass, timeout, err, latency
    );

    modport slave (
        input  start, mode, block, key, expected,
        output busy, done, pass, timeout, err, latency
    );
endinterface

// File: rtl/cipher_uut_sequencer.sv
// Driver/checker for one block-cipher UUT. Each accepted start runs UUT reset,
// key schedule and the cipher operation (twice for encrypt-then-decrypt
// roundtrip), then compares the captured result and updates pass/fail counts.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   host            : request/verdict bundle (slave side)
//   rst_uut_o       : UUT reset, active-high
//   encdec_uut_o    : 1 encrypt, 0 decrypt
//   block_uut_o/key_uut_o : operands to the UUT
//   block_uut_i     : UUT result
//   end_*_uut_i     : UUT completion levels (key schedule, enc, dec)
//   sw_debug_i      : debug bank select
//   debug_o         : selected debug word
module cipher_uut_sequencer #(
    parameter int unsigned BLOCK_W        = 64,
    parameter int unsigned KEY_W          = 80,
    parameter int unsigned RST_CYCLES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned DEBUG_W        = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cipher_uut_sequencer_if.slave  host,
    output logic                   rst_uut_o,
    output logic                   encdec_uut_o,
    output logic [BLOCK_W-1:0]     block_uut_o,
    output logic [KEY_W-1:0]       key_uut_o,
    input  logic [BLOCK_W-1:0]     block_uut_i,
    input  logic                   end_key_uut_i,
    input  logic                   end_enc_uut_i,
    input  logic                   end_dec_uut_i,
    input  logic [1:0]             sw_debug_i,
    output logic [DEBUG_W-1:0]     debug_o
);
    localparam int unsigned TIMER_MAX = (TIMEOUT_CYCLES > RST_CYCLES) ? TIMEOUT_CYCLES : RST_CYCLES;
    localparam int unsigned TIMER_W   = $clog2(TIMER_MAX + 1);
    localparam int unsigned CAP_EXT_W = 2 * DEBUG_W;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StRstUut = 3'd1,
        StKeygen = 3'd2,
        StOp     = 3'd3,
        StCheck  = 3'd4,
        StDone   = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0]   lat_q, lat_d;
    logic [CNT_W-1:0]   pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0]   fail_cnt_q, fail_cnt_d;
    logic [BLOCK_W-1:0] blk_q, blk_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [BLOCK_W-1:0] ref_q, ref_d;   // expected_i, or plaintext in roundtrip
    logic [BLOCK_W-1:0] cap_q, cap_d;
    logic               encdec_q, encdec_d;
    logic               rt_q, rt_d;
    logic               pass_q, pass_d;
    logic               timeout_q, timeout_d;
    logic               err_q, err_d;
    logic               op_end;
    logic               tmo_hit;
    logic [CAP_EXT_W-1:0] cap_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            lat_q      <= '0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
            blk_q      <= '0;
            key_q      <= '0;
            ref_q      <= '0;
            cap_q      <= '0;
            encdec_q   <= 1'b0;
            rt_q       <= 1'b0;
            pass_q     <= 1'b0;
            timeout_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            lat_q      <= lat_d;
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            blk_q      <= blk_d;
            key_q      <= key_d;
            ref_q      <= ref_d;
            cap_q      <= cap_d;
            encdec_q   <= encdec_d;
            rt_q       <= rt_d;
            pass_q     <= pass_d;
            timeout_q  <= timeout_d;
            err_q      <= err_d;
        end
    end

    assign op_end  = encdec_q ? end_enc_uut_i : end_dec_uut_i;
    assign tmo_hit = (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        lat_d      = lat_q;
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        blk_d      = blk_q;
        key_d      = key_q;
        ref_d      = ref_q;
        cap_d      = cap_q;
        encdec_d   = encdec_q;
        rt_d       = rt_q;
        pass_d     = pass_q;
        timeout_d  = timeout_q;
        err_d      = err_q;

        unique case (state_q)
            StIdle: begin
                if (host.start) begin
                    pass_d    = 1'b0;
                    timeout_d = 1'b0;
                    if (host.mode == 2'd3) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        err_d    = 1'b0;
                        blk_d    = host.block;
                        key_d    = host.key;
                        ref_d    = (host.mode == 2'd2) ? host.block : host.expected;
                        encdec_d = (host.mode != 2'd1);
                        rt_d     = (host.mode == 2'd2);
                        timer_d  = '0;
                        state_d  = StRstUut;
                    end
                end
            end
            StRstUut: begin
                if (timer_q == TIMER_W'(RST_CYCLES - 1)) begin
                    timer_d = '0;
                    state_d = StKeygen;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            StKeygen: begin
                if (end_key_uut_i) begin
                    timer_d = '0;
                    lat_d   = '0;
                    state_d = StOp;
                end else if (tmo_hit) begin
                    timeout_d  = 1'b1;
                    pass_d     = 1'b0;
                    fail_cnt_d = (fail_cnt_q == '1) ? fail_cnt_q : fail_cnt_q + CNT_W'(1);
                    state_d    = StDone;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            StOp: begin
                if (op_end) begin
                    cap_d = block_uut_i;
                    if (rt_q && encdec_q) begin
                        // Roundtrip: ciphertext feeds the decrypt pass.
                        blk_d    = block_uut_i;
                        encdec_d = 1'b0;
                        timer_d  = '0;
                        state_d  = StRstUut;
                    end else begin
                        state_d = StCheck;
                    end
                end else if (tmo_hit) begin
                    timeout_d  = 1'b1;
                    pass_d     = 1'b0;
                    fail_cnt_d = (fail_cnt_q == '1) ? fail_cnt_q : fail_cnt_q + CNT_W'(1);
                    state_d    = StDone;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                    lat_d   = (lat_q == '1) ? lat_q : lat_q + CNT_W'(1);
                end
            end
            StCheck: begin
                if (cap_q == ref_q) begin
                    pass_d     = 1'b1;
                    pass_cnt_d = (pass_cnt_q == '1) ? pass_cnt_q : pass_cnt_q + CNT_W'(1);
                end else begin
                    fail_cnt_d = (fail_cnt_q == '1) ? fail_cnt_q : fail_cnt_q + CNT_W'(1);
                end
                state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign host.busy    = (state_q != StIdle) && (state_q != StDone);
    assign host.done    = (state_q == StDone);
    assign host.pass    = pass_q;
    assign host.timeout = timeout_q;
    assign host.err     = err_q;
    assign host.latency = lat_q;

    assign rst_uut_o    = (state_q == StIdle) || (state_q == StRstUut);
    assign encdec_uut_o = encdec_q;
    assign block_uut_o  = blk_q;
    assign key_uut_o    = key_q;

    always_comb begin
        cap_ext = CAP_EXT_W'(cap_q);
        case (sw_debug_i)
            2'd0:    debug_o = cap_ext[DEBUG_W-1:0];
            2'd1:    debug_o = cap_ext[CAP_EXT_W-1:DEBUG_W];
            2'd2:    debug_o = DEBUG_W'({state_q, lat_q});
            default: debug_o = DEBUG_W'({pass_cnt_q, fail_cnt_q});
        endcase
    end
endmodule

// File: tb/tb_cipher_uut_sequencer.sv
// Bench for cipher_uut_sequencer: a PRESENT-80 behavioural UUT with
// programmable key-schedule/operation latencies, plus scenario tasks.
module tb_cipher_uut_sequencer;
    localparam int unsigned BLOCK_W        = 64;
    localparam int unsigned KEY_W          = 80;
    localparam int unsigned RST_CYCLES     = 4;
    localparam int unsigned TIMEOUT_CYCLES = 4096;
    localparam int unsigned CNT_W          = 16;
    localparam int unsigned DEBUG_W        = 32;
    localparam int          BOUND          = 2 * TIMEOUT_CYCLES + 200;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cipher_uut_sequencer_if #(.BLOCK_W(BLOCK_W), .KEY_W(KEY_W), .CNT_W(CNT_W)) host_if ();

    logic               rst_uut, encdec_uut, end_key, end_enc, end_dec;
    logic [BLOCK_W-1:0] blk_to_uut, res_from_uut;
    logic [KEY_W-1:0]   key_to_uut;
    logic [1:0]         sw_debug;
    logic [DEBUG_W-1:0] debug;

    cipher_uut_sequencer #(
        .BLOCK_W(BLOCK_W), .KEY_W(KEY_W), .RST_CYCLES(RST_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(CNT_W), .DEBUG_W(DEBUG_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .host(host_if.slave),
        .rst_uut_o(rst_uut), .encdec_uut_o(encdec_uut), .block_uut_o(blk_to_uut),
        .key_uut_o(key_to_uut), .block_uut_i(res_from_uut), .end_key_uut_i(end_key),
        .end_enc_uut_i(end_enc), .end_dec_uut_i(end_dec), .sw_debug_i(sw_debug),
        .debug_o(debug)
    );

    // ---------------- PRESENT-80 reference ----------------
    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: return 4'hC; 4'h1: return 4'h5; 4'h2: return 4'h6; 4'h3: return 4'hB;
            4'h4: return 4'h9; 4'h5: return 4'h0; 4'h6: return 4'hA; 4'h7: return 4'hD;
            4'h8: return 4'h3; 4'h9: return 4'hE; 4'hA: return 4'hF; 4'hB: return 4'h8;
            4'hC: return 4'h4; 4'hD: return 4'h7; 4'hE: return 4'h1; default: return 4'h2;
        endcase
    endfunction

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        for (int v = 0; v < 16; v++) if (sbox(4'(v)) == x) return 4'(v);
        return 4'h0;
    endfunction

    function automatic logic [63:0] round_key(input logic [79:0] k, input int r);
        logic [79:0] kk;
        kk = k;
        for (int i = 1; i < r; i++) begin
            kk = {kk[18:0], kk[79:19]};
            kk[79:76] = sbox(kk[79:76]);
            kk[19:15] = kk[19:15] ^ 5'(i);
        end
        return kk[79:16];
    endfunction

    function automatic logic [63:0] s_layer(input logic [63:0] s, input bit inv);
        logic [63:0] o;
        for (int n = 0; n < 16; n++) o[4*n +: 4] = inv ? sbox_inv(s[4*n +: 4]) : sbox(s[4*n +: 4]);
        return o;
    endfunction

    function automatic int p_pos(input int i);
        return (i == 63) ? 63 : (i * 16) % 63;
    endfunction

    function automatic logic [63:0] p_layer(input logic [63:0] s, input bit inv);
        logic [63:0] o;
        o = '0;
        for (int i = 0; i < 64; i++) begin
            if (inv) o[i] = s[p_pos(i)];
            else     o[p_pos(i)] = s[i];
        end
        return o;
    endfunction

    function automatic logic [63:0] present_enc(input logic [63:0] pt, input logic [79:0] k);
        logic [63:0] s;
        s = pt;
        for (int r = 1; r <= 31; r++) s = p_layer(s_layer(s ^ round_key(k, r), 1'b0), 1'b0);
        return s ^ round_key(k, 32);
    endfunction

    function automatic logic [63:0] present_dec(input logic [63:0] ct, input logic [79:0] k);
        logic [63:0] s;
        s = ct ^ round_key(k, 32);
        for (int r = 31; r >= 1; r--) s = s_layer(p_layer(s, 1'b1), 1'b1) ^ round_key(k, r);
        return s;
    endfunction

    // ---------------- behavioural UUT ----------------
    // end_key rises key_lat cycles after UUT reset release; the op flag rises
    // so that exactly lat_* cycles elapse in the sequencer's OP phase before it.
    int   key_lat = 0, lat_enc = 0, lat_dec = 0;
    bit   key_hang = 1'b0, op_hang = 1'b0;
    logic [7:0]  kcnt, ocnt;
    logic [63:0] res;

    always @(posedge clk) begin
        if (rst_uut) begin
            kcnt <= '0;
            ocnt <= '0;
            res  <= encdec_uut ? present_enc(blk_to_uut, key_to_uut)
                               : present_dec(blk_to_uut, key_to_uut);
        end else begin
            if (kcnt != 8'hFF) kcnt <= kcnt + 8'd1;
            if (end_key && ocnt != 8'hFF) ocnt <= ocnt + 8'd1;
        end
    end

    assign end_key      = !key_hang && (int'(kcnt) >= key_lat);
    assign end_enc      = encdec_uut && !op_hang && (int'(ocnt) > lat_enc);
    assign end_dec      = !encdec_uut && !op_hang && (int'(ocnt) > lat_dec);
    assign res_from_uut = res;

    // ---------------- scoreboard state ----------------
    int          n_checks = 0, n_pass = 0;
    logic [15:0] exp_pass = '0, exp_fail = '0;
    logic [63:0] exp_cap = '0;

    function automatic int exp_cycles(input int mode, input int kl, input int le, input int ld);
        int f;
        f = int'(RST_CYCLES) + kl + 1;
        case (mode)
            0:       return f + le + 1 + 2;
            1:       return f + ld + 1 + 2;
            default: return 2 * f + le + ld + 2 + 2;
        endcase
    endfunction

    // Drives one request and observes until done_o (bounded).
    task automatic run_vec(input logic [1:0] mode, input logic [63:0] blk, input logic [79:0] key,
                           input logic [63:0] expv, input int poke_at, output int cycles,
                           output bit got_done, output int busy_cyc, output int rst_hi,
                           output int rst_pulses);
        bit prev;
        cycles = 0; got_done = 0; busy_cyc = 0; rst_hi = 0; rst_pulses = 0; prev = 0;
        @(posedge clk); #1;
        host_if.start = 1'b1; host_if.mode = mode; host_if.block = blk;
        host_if.key = key; host_if.expected = expv;
        @(posedge clk); #1;
        host_if.start = 1'b0; host_if.block = ~blk; host_if.key = ~key; host_if.expected = ~expv;
        while (cycles < BOUND) begin
            cycles++;
            if (host_if.busy) busy_cyc++;
            if (host_if.busy && rst_uut) begin
                rst_hi++;
                if (!prev) rst_pulses++;
            end
            prev = host_if.busy && rst_uut;
            if (host_if.done) begin
                got_done = 1'b1;
                break;
            end
            if (cycles == poke_at) begin
                host_if.start = 1'b1; host_if.mode = 2'd3;
            end
            @(posedge clk); #1;
            host_if.start = 1'b0;
        end
    endtask

    task automatic test_reset();
        n_checks++; if (rst_uut !== 1'b1) $display("FAIL reset rst_uut: got %b want 1", rst_uut); else n_pass++;
        n_checks++; if (host_if.busy !== 1'b0) $display("FAIL reset busy: got %b want 0", host_if.busy); else n_pass++;
        n_checks++; if (host_if.done !== 1'b0) $display("FAIL reset done: got %b want 0", host_if.done); else n_pass++;
        n_checks++;
        if ({host_if.pass, host_if.timeout, host_if.err} !== 3'b000)
            $display("FAIL reset flags: got %b want 000", {host_if.pass, host_if.timeout, host_if.err});
        else n_pass++;
        n_checks++; if (host_if.latency !== '0) $display("FAIL reset latency: got %0d want 0", host_if.latency); else n_pass++;
        n_checks++; if (blk_to_uut !== '0) $display("FAIL reset block_uut: got %h want 0", blk_to_uut); else n_pass++;
        sw_debug = 2'd3; #1;
        n_checks++; if (debug !== '0) $display("FAIL reset counters: got %h want 0", debug); else n_pass++;
        sw_debug = 2'd0; #1;
        n_checks++; if (debug !== '0) $display("FAIL reset capture: got %h want 0", debug); else n_pass++;
    endtask

    task automatic test_known_vectors();
        int c, bc, rh, rp; bit d;
        key_hang = 0; op_hang = 0;
        // Encrypt, all-zero key and plaintext.
        key_lat = 3; lat_enc = 5; lat_dec = 9;
        run_vec(2'd0, 64'h0, 80'h0, 64'h5579C1387B228445, 0, c, d, bc, rh, rp);
        exp_pass++; exp_cap = 64'h5579C1387B228445;
        n_checks++; if (!d) $display("FAIL k_enc done: got 0 want 1"); else n_pass++;
        n_checks++; if (c !== exp_cycles(0, 3, 5, 9)) $display("FAIL k_enc cycles: got %0d want %0d", c, exp_cycles(0, 3, 5, 9)); else n_pass++;
        n_checks++; if (host_if.pass !== 1'b1) $display("FAIL k_enc pass: got %b want 1", host_if.pass); else n_pass++;
        n_checks++; if (host_if.busy !== 1'b0) $display("FAIL k_enc busy_in_done: got %b want 0", host_if.busy); else n_pass++;
        n_checks++; if (bc !== c - 1) $display("FAIL k_enc busy_cycles: got %0d want %0d", bc, c - 1); else n_pass++;
        n_checks++; if (host_if.latency !== 16'd5) $display("FAIL k_enc latency: got %0d want 5", host_if.latency); else n_pass++;
        sw_debug = 2'd3; #1;
        n_checks++; if (debug !== {exp_pass, exp_fail}) $display("FAIL k_enc counters: got %h want %h", debug, {exp_pass, exp_fail}); else n_pass++;
        sw_debug = 2'd1; #1;
        n_checks++; if (debug !== exp_cap[63:32]) $display("FAIL k_enc cap_hi: got %h want %h", debug, exp_cap[63:32]); else n_pass++;
        // Decrypt back to zero.
        key_lat = 0; lat_enc = 2; lat_dec = 7;
        run_vec(2'd1, 64'h5579C1387B228445, 80'h0, 64'h0, 0, c, d, bc, rh, rp);
        exp_pass++; exp_cap = 64'h0;
        n_checks++; if (!d || host_if.pass !== 1'b1) $display("FAIL k_dec pass: got %b want 1", host_if.pass); else n_pass++;
        n_checks++; if (host_if.latency !== 16'd7) $display("FAIL k_dec latency: got %0d want 7", host_if.latency); else n_pass++;
        n_checks++; if (c !== exp_cycles(1, 0, 2, 7)) $display("FAIL k_dec cycles: got %0d want %0d", c, exp_cycles(1, 0, 2, 7)); else n_pass++;
        // Roundtrip, all-ones key; latency must reflect the decrypt phase.
        key_lat = 2; lat_enc = 4; lat_dec = 11;
        run_vec(2'd2, 64'h0123456789ABCDEF, {KEY_W{1'b1}}, 64'hDEAD, 0, c, d, bc, rh, rp);
        exp_pass++; exp_cap = 64'h0123456789ABCDEF;
        n_checks++; if (!d || host_if.pass !== 1'b1) $display("FAIL k_rt pass: got %b want 1", host_if.pass); else n_pass++;
        n_checks++; if (rp !== 2) $display("FAIL k_rt rst_pulses: got %0d want 2", rp); else n_pass++;
        n_checks++; if (rh !== 2 * int'(RST_CYCLES)) $display("FAIL k_rt rst_cycles: got %0d want %0d", rh, 2 * RST_CYCLES); else n_pass++;
        n_checks++; if (host_if.latency !== 16'd11) $display("FAIL k_rt latency: got %0d want 11", host_if.latency); else n_pass++;
        n_checks++; if (c !== exp_cycles(2, 2, 4, 11)) $display("FAIL k_rt cycles: got %0d want %0d", c, exp_cycles(2, 2, 4, 11)); else n_pass++;
    endtask

    task automatic test_timeout();
        int c, bc, rh, rp, want; bit d;
        key_hang = 1; op_hang = 0; key_lat = 0; lat_enc = 0;
        run_vec(2'd0, 64'h1111, 80'h2222, 64'h0, 0, c, d, bc, rh, rp);
        exp_fail++;
        want = int'(RST_CYCLES) + int'(TIMEOUT_CYCLES) + 1;
        n_checks++; if (!d || c !== want) $display("FAIL tmo_key cycles: got %0d (done %b) want %0d", c, d, want); else n_pass++;
        n_checks++; if (host_if.timeout !== 1'b1) $display("FAIL tmo_key timeout: got %b want 1", host_if.timeout); else n_pass++;
        n_checks++; if (host_if.pass !== 1'b0) $display("FAIL tmo_key pass: got %b want 0", host_if.pass); else n_pass++;
        sw_debug = 2'd3; #1;
        n_checks++; if (debug !== {exp_pass, exp_fail}) $display("FAIL tmo_key counters: got %h want %h", debug, {exp_pass, exp_fail}); else n_pass++;
        key_hang = 0; op_hang = 1; key_lat = 3;
        run_vec(2'd1, 64'h3333, 80'h4444, 64'h0, 0, c, d, bc, rh, rp);
        exp_fail++;
        want = int'(RST_CYCLES) + 3 + 1 + int'(TIMEOUT_CYCLES) + 1;
        n_checks++; if (!d || c !== want) $display("FAIL tmo_op cycles: got %0d (done %b) want %0d", c, d, want); else n_pass++;
        n_checks++; if (host_if.timeout !== 1'b1) $display("FAIL tmo_op timeout: got %b want 1", host_if.timeout); else n_pass++;
        sw_debug = 2'd3; #1;
        n_checks++; if (debug !== {exp_pass, exp_fail}) $display("FAIL tmo_op counters: got %h want %h", debug, {exp_pass, exp_fail}); else n_pass++;
        sw_debug = 2'd0; #1;
        n_checks++; if (debug !== exp_cap[31:0]) $display("FAIL tmo_op cap_kept: got %h want %h", debug, exp_cap[31:0]); else n_pass++;
        op_hang = 0;
    endtask

    task automatic test_mismatch_and_illegal();
        int c, bc, rh, rp; bit d;
        logic [63:0] ct;
        key_lat = 1; lat_enc = 3; lat_dec = 3;
        ct = present_enc(64'hCAFEF00D12345678, 80'h0BADC0DE);
        run_vec(2'd0, 64'hCAFEF00D12345678, 80'h0BADC0DE, ct ^ 64'h100, 0, c, d, bc, rh, rp);
        exp_fail++; exp_cap = ct;
        n_checks++; if (!d || host_if.pass !== 1'b0) $display("FAIL mism pass: got %b want 0", host_if.pass); else n_pass++;
        n_checks++; if (host_if.timeout !== 1'b0) $display("FAIL mism timeout: got %b want 0", host_if.timeout); else n_pass++;
        sw_debug = 2'd3; #1;
        n_checks++; if (debug !== {exp_pass, exp_fail}) $display("FAIL mism counters: got %h want %h", debug, {exp_pass, exp_fail}); else n_pass++;
        run_vec(2'd3, 64'h5, 80'h6, 64'h7, 0, c, d, bc, rh, rp);
        n_checks++; if (!d || c !== 1) $display("FAIL illegal done_cycle: got %0d want 1", c); else n_pass++;
        n_checks++; if (host_if.err !== 1'b1) $display("FAIL illegal err: got %b want 1", host_if.err); else n_pass++;
        n_checks++; if (bc !== 0 || rp !== 0) $display("FAIL illegal busy/rst: got %0d/%0d want 0/0", bc, rp); else n_pass++;
        sw_debug = 2'd3; #1;
        n_checks++; if (debug !== {exp_pass, exp_fail}) $display("FAIL illegal counters: got %h want %h", debug, {exp_pass, exp_fail}); else n_pass++;
    endtask

    task automatic test_start_while_busy();
        int c, bc, rh, rp; bit d;
        logic [63:0] ct;
        key_lat = 2; lat_enc = 6; lat_dec = 1;
        ct = present_enc(64'h0F0E0D0C0B0A0908, 80'h1234);
        run_vec(2'd0, 64'h0F0E0D0C0B0A0908, 80'h1234, ct, 3, c, d, bc, rh, rp);
        exp_pass++; exp_cap = ct;
        n_checks++; if (!d || host_if.pass !== 1'b1) $display("FAIL busy_start pass: got %b want 1", host_if.pass); else n_pass++;
        n_checks++; if (host_if.err !== 1'b0) $display("FAIL busy_start err: got %b want 0", host_if.err); else n_pass++;
        n_checks++; if (c !== exp_cycles(0, 2, 6, 1)) $display("FAIL busy_start cycles: got %0d want %0d", c, exp_cycles(0, 2, 6, 1)); else n_pass++;
    endtask

    task automatic test_random();
        int c, bc, rh, rp, mode, want_lat; bit d, wrong;
        logic [63:0] pt, ct, blk, good, expv;
        logic [79:0] key;
        for (int it = 0; it < 14; it++) begin
            mode = int'($urandom_range(2, 0));
            key = {16'($urandom), $urandom, $urandom};
            pt = {$urandom, $urandom};
            key_lat = int'($urandom_range(20, 0));
            lat_enc = int'($urandom_range(20, 0));
            lat_dec = int'($urandom_range(20, 0));
            ct = present_enc(pt, key);
            blk  = (mode == 1) ? ct : pt;
            good = (mode == 0) ? ct : pt;
            wrong = (mode != 2) && ($urandom_range(3, 0) == 0);
            expv = (mode == 2) ? {$urandom, $urandom} : (wrong ? good ^ ({$urandom, $urandom} | 64'h1) : good);
            run_vec(2'(mode), blk, key, expv, 0, c, d, bc, rh, rp);
            if (wrong) exp_fail++; else exp_pass++;
            exp_cap = good;
            want_lat = (mode == 0) ? lat_enc : lat_dec;
            n_checks++; if (!d || c !== exp_cycles(mode, key_lat, lat_enc, lat_dec)) $display("FAIL rnd%0d cycles: got %0d want %0d", it, c, exp_cycles(mode, key_lat, lat_enc, lat_dec)); else n_pass++;
            n_checks++; if (host_if.pass !== !wrong) $display("FAIL rnd%0d pass: got %b want %b", it, host_if.pass, !wrong); else n_pass++;
            n_checks++; if (host_if.latency !== 16'(want_lat)) $display("FAIL rnd%0d latency: got %0d want %0d", it, host_if.latency, want_lat); else n_pass++;
            sw_debug = 2'd3; #1;
            n_checks++; if (debug !== {exp_pass, exp_fail}) $display("FAIL rnd%0d counters: got %h want %h", it, debug, {exp_pass, exp_fail}); else n_pass++;
            sw_debug = 2'd0; #1;
            n_checks++; if (debug !== exp_cap[31:0]) $display("FAIL rnd%0d cap_lo: got %h want %h", it, debug, exp_cap[31:0]); else n_pass++;
            sw_debug = 2'd2; #1;
            n_checks++; if (debug[15:0] !== 16'(want_lat)) $display("FAIL rnd%0d dbg_lat: got %0d want %0d", it, debug[15:0], want_lat); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_op();
        int c, bc, rh, rp, dcount; bit d;
        logic [63:0] ct;
        key_lat = 2; lat_enc = 60; key_hang = 0; op_hang = 0;
        @(posedge clk); #1;
        host_if.start = 1'b1; host_if.mode = 2'd0; host_if.block = 64'h1; host_if.key = 80'h2;
        @(posedge clk); #1;
        host_if.start = 1'b0;
        repeat (RST_CYCLES + 8) @(posedge clk);
        #1;
        n_checks++; if (host_if.busy !== 1'b1) $display("FAIL rst_mid busy_before: got %b want 1", host_if.busy); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (rst_uut !== 1'b1) $display("FAIL rst_mid rst_uut: got %b want 1", rst_uut); else n_pass++;
        n_checks++; if (host_if.busy !== 1'b0) $display("FAIL rst_mid busy: got %b want 0", host_if.busy); else n_pass++;
        dcount = 0;
        @(posedge clk); #1;
        if (host_if.done) dcount++;
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            if (host_if.done) dcount++;
        end
        n_checks++; if (dcount !== 0) $display("FAIL rst_mid done_seen: got %0d want 0", dcount); else n_pass++;
        exp_pass = '0; exp_fail = '0;
        sw_debug = 2'd3; #1;
        n_checks++; if (debug !== '0) $display("FAIL rst_mid counters: got %h want 0", debug); else n_pass++;
        n_checks++; if (host_if.latency !== '0) $display("FAIL rst_mid latency: got %0d want 0", host_if.latency); else n_pass++;
        lat_enc = 4;
        ct = present_enc(64'h8899AABBCCDDEEFF, 80'h77);
        run_vec(2'd0, 64'h8899AABBCCDDEEFF, 80'h77, ct, 0, c, d, bc, rh, rp);
        exp_pass++;
        n_checks++; if (!d || host_if.pass !== 1'b1) $display("FAIL rst_mid rerun_pass: got %b want 1", host_if.pass); else n_pass++;
        sw_debug = 2'd3; #1;
        n_checks++; if (debug !== {exp_pass, exp_fail}) $display("FAIL rst_mid rerun_counters: got %h want %h", debug, {exp_pass, exp_fail}); else n_pass++;
    endtask

    initial begin
        host_if.start = 1'b0; host_if.mode = 2'd0; host_if.block = '0;
        host_if.key = '0; host_if.expected = '0; sw_debug = 2'd0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_known_vectors();
        test_timeout();
        test_mismatch_and_illegal();
        test_start_while_busy();
        test_random();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
